rr_mux_arbiter: RTL and testbench

Four-requester round-robin arbiter that owns the select lines of a 4:1 data multiplexer and shares one output channel between four sources. It grants one requester at a time and holds the grant for a burst, bounded by a `last` flag or a beat limit. It then rotates priority and drives the mux select, so the datapath downstream sees one valid/ready stream.

---
 rtl/rr_mux_arbiter.sv | 83 ++++++++
 tb/tb_rr_mux_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: 4-way round-robin burst arbiter driving a 4:1 data mux select.
module rr_mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [3:0]       ack
);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        r_state;
  logic [1:0]    r_ptr, r_sel;
  logic [3:0]    r_gnt;
  logic [CW-1:0] r_cnt;
  logic             w_busy, w_vld, w_xfer, w_last, w_end;
  logic [1:0]       w_nptr;
  logic [2:0]       w_pk_idle, w_pk_end;
  logic [WIDTH-1:0] w_mux;
  // {found, index} of the first requester at or after p, wrapping mod 4
  function automatic logic [2:0] f_pick(input logic [3:0] rq, input logic [1:0] p);
    logic [2:0] r;
    r = '0;
    for (int j = 3; j >= 0; j--)
      if (rq[p + 2'(j)]) r = {1'b1, p + 2'(j)};
    return r;
  endfunction
  assign w_busy    = r_state == BUSY;
  assign w_vld     = w_busy & req[r_sel];
  assign w_xfer    = w_vld & out_ready;
  assign w_last    = w_vld & (last[r_sel] | (r_cnt == CW'(MAX_BURST - 1)));
  assign w_end     = w_busy & (~req[r_sel] | (w_xfer & w_last));
  assign w_nptr    = r_sel + 2'd1;
  assign w_pk_idle = f_pick(req, r_ptr);
  assign w_pk_end  = f_pick(req, w_nptr);
  assign w_mux     = r_sel == 2'd0 ? i0 : r_sel == 2'd1 ? i1 : r_sel == 2'd2 ? i2 : i3;
  assign out_valid = w_vld;
  assign out_data  = w_vld ? w_mux : '0;
  assign out_last  = w_last;
  assign ack       = w_xfer ? r_gnt : 4'b0000;
  assign gnt       = r_gnt;
  assign sel       = r_sel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else if (!w_busy) begin
      if (w_pk_idle[2]) begin
        r_state <= BUSY;
        r_sel   <= w_pk_idle[1:0];
        r_gnt   <= 4'b0001 << w_pk_idle[1:0];
        r_cnt   <= '0;
      end
    end else if (w_end) begin
      r_ptr <= w_nptr;
      r_cnt <= '0;
      if (w_pk_end[2]) begin
        r_sel <= w_pk_end[1:0];
        r_gnt <= 4'b0001 << w_pk_end[1:0];
      end else begin
        r_state <= IDLE;
        r_gnt   <= '0;
      end
    end else if (w_xfer) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed and randomized checks of rr_mux_arbiter against a behavioural model.
module tb_rr_mux_arbiter;
  localparam int MB = 4;
  logic       clk = 0, rst = 1, out_ready = 1;
  logic [3:0] req = 0, last = 0;
  logic [7:0] src [4];
  logic [7:0] out_data;
  logic       out_valid, out_last;
  logic [3:0] gnt, ack;
  logic [1:0] sel;
  int n_cmp = 0, n_bad = 0;
  int m_busy = 0, m_ptr = 0, m_sel = 0, m_beats = 0;

  rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .i0(src[0]), .i1(src[1]), .i2(src[2]), .i3(src[3]),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .gnt(gnt), .sel(sel), .ack(ack)
  );

  always #5 clk = ~clk;

  function automatic int pick4(input logic [3:0] rq, input int p);
    for (int j = 0; j < 4; j++) if (rq[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // model: a grant serves one source until its last beat, the beat limit, or its req drops
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_ptr <= 0; m_sel <= 0; m_beats <= 0;
    end else if (m_busy == 0) begin
      if (pick4(req, m_ptr) >= 0) begin
        m_busy <= 1; m_sel <= pick4(req, m_ptr); m_beats <= 0;
      end
    end else if (!req[m_sel] || (out_ready && (last[m_sel] || m_beats == MB - 1))) begin
      m_ptr   <= (m_sel + 1) % 4;
      m_beats <= 0;
      if (pick4(req, (m_sel + 1) % 4) >= 0) m_sel <= pick4(req, (m_sel + 1) % 4);
      else m_busy <= 0;
    end else if (out_ready) begin
      m_beats <= m_beats + 1;
    end
  end

  always @(negedge clk) begin
    logic v;
    v = !rst && m_busy != 0 && req[m_sel];
    chk("gnt", {28'd0, gnt}, (!rst && m_busy != 0) ? (32'd1 << m_sel) : 32'd0);
    chk("sel", {30'd0, sel}, rst ? 32'd0 : m_sel);
    chk("out_valid", {31'd0, out_valid}, {31'd0, v});
    chk("out_data", {24'd0, out_data}, v ? {24'd0, src[m_sel]} : 32'd0);
    chk("out_last", {31'd0, out_last}, {31'd0, v && (last[m_sel] || m_beats == MB - 1)});
    chk("ack", {28'd0, ack}, (v && out_ready) ? (32'd1 << m_sel) : 32'd0);
  end

  initial begin
    src[0] = 8'h10; src[1] = 8'h21; src[2] = 8'h32; src[3] = 8'h43;
    req = 4'b1111;
    tick; tick; #1;
    chk("rst_gnt", {28'd0, gnt}, 0);
    chk("rst_sel", {30'd0, sel}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    rst = 0;
    tick; #1;
    chk("rel_gnt", {28'd0, gnt}, 4'b0001);
    req = 0;
    tick;
    req = 4'b0100; src[2] = 8'hA5;
    tick; #1;
    chk("single_gnt", {28'd0, gnt}, 4'b0100);
    chk("single_sel", {30'd0, sel}, 2'b10);
    chk("single_data", {24'd0, out_data}, 8'hA5);
    chk("single_ack1", {28'd0, ack}, 4'b0100);
    chk("single_nolast", {31'd0, out_last}, 0);
    tick;
    last = 4'b0100; #1;
    chk("single_ack2", {28'd0, ack}, 4'b0100);
    chk("single_last", {31'd0, out_last}, 1);
    tick; #1;
    chk("single_regrant", {28'd0, gnt}, 4'b0100);
    req = 0; last = 0;
    tick; #1;
    chk("single_idle", {28'd0, gnt}, 0);
    rst = 1; req = 4'b1111; last = 4'b1111;
    tick;
    rst = 0;
    tick;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt", {28'd0, gnt}, 32'd1 << (i % 4));
      chk("rr_ack", {28'd0, ack}, 32'd1 << (i % 4));
      tick;
    end
    req = 0; last = 0;
    tick;
    req = 4'b0011;
    tick;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("burst_ack", {28'd0, ack}, 4'b0001);
      chk("burst_last", {31'd0, out_last}, (b == 3) ? 1 : 0);
      tick;
    end
    #1;
    chk("burst_next", {28'd0, gnt}, 4'b0010);
    out_ready = 0; req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ack", {28'd0, ack}, 0);
      chk("bp_gnt", {28'd0, gnt}, 4'b0010);
      chk("bp_valid", {31'd0, out_valid}, 1);
      tick;
    end
    out_ready = 1; last = 4'b0010; #1;
    chk("bp_xfer", {28'd0, ack}, 4'b0010);
    chk("bp_last", {31'd0, out_last}, 1);
    tick;
    req = 0; last = 0;
    tick;
    req = 4'b1000;
    tick; #1;
    chk("abort_g3", {28'd0, gnt}, 4'b1000);
    req = 4'b0001;
    tick; #1;
    chk("abort_g0", {28'd0, gnt}, 4'b0001);
    chk("abort_valid", {31'd0, out_valid}, 1);
    rst = 1; #1;
    chk("mrst_valid", {31'd0, out_valid}, 0);
    chk("mrst_gnt", {28'd0, gnt}, 0);
    chk("mrst_ack", {28'd0, ack}, 0);
    chk("mrst_data", {24'd0, out_data}, 0);
    tick;
    rst = 0;
    repeat (400) begin
      req = 4'($urandom);
      last = 4'($urandom) & 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      for (int k = 0; k < 4; k++) src[k] = 8'($urandom);
      tick;
    end
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
